// File: rtl/mips_dbg_pkg.sv
// Shared tags and FSM encoding for the MIPS state dump engine.
// MIPS_DUMP_CHECKSUM_EN adds the checksum state.
package mips_dbg_pkg;

  localparam logic [1:0] TAG_REG  = 2'd0;
  localparam logic [1:0] TAG_MEM  = 2'd1;
  localparam logic [1:0] TAG_CSUM = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_REGS,
    ST_MEM,
`ifdef MIPS_DUMP_CHECKSUM_EN
    ST_CSUM,
`endif
    ST_DONE
  } dump_state_t;

endpackage

// File: rtl/dump_out_reg.sv
// Valid/ready holding register for one dump record.
// load_en tells the producer that its record was captured.
module dump_out_reg #(
  parameter int TAG_W  = 2,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              out_ready,
  output logic              load_en,
  output logic              out_valid,
  output logic [TAG_W-1:0]  out_tag,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data
);

  assign load_en = in_valid && (!out_valid || out_ready);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_tag   <= '0;
      out_addr  <= '0;
      out_data  <= '0;
    end else if (load_en) begin
      out_valid <= 1'b1;
      out_tag   <= in_tag;
      out_addr  <= in_addr;
      out_data  <= in_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/mips_state_dump.sv
// Halts the core and streams register file then data memory.
// MIPS_DUMP_CHECKSUM_EN appends a wrapping-sum record.
module mips_state_dump
  import mips_dbg_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int REG_AW    = 4,
  parameter int MEM_AW    = 8,
  parameter int MEM_WORDS = 2**MEM_AW,
  parameter int ADDR_W    = (REG_AW > MEM_AW) ? REG_AW : MEM_AW
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  output logic              halt,
  output logic              busy,
  output logic              done,
  output logic [REG_AW-1:0] reg_rd_addr,
  input  logic [DATA_W-1:0] reg_rd_data,
  output logic [MEM_AW-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        out_tag,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data
);

  localparam logic [MEM_AW-1:0] MEM_LAST = MEM_AW'(MEM_WORDS - 1);

  dump_state_t       state, state_d;
  logic [REG_AW-1:0] reg_cnt, reg_cnt_d;
  logic [MEM_AW-1:0] mem_cnt, mem_cnt_d;
  logic              fin, fin_d;
  logic              in_valid, load_en, drained;
  logic [1:0]        in_tag;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_data;

  assign drained = out_valid && out_ready;

`ifdef MIPS_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] sum;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      sum <= '0;
    else if (state == ST_SETTLE)
      sum <= '0;
    else if (load_en && in_tag != TAG_CSUM)
      sum <= sum + in_data;
  end
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      reg_cnt <= '0;
      mem_cnt <= '0;
      fin     <= 1'b0;
    end else begin
      state   <= state_d;
      reg_cnt <= reg_cnt_d;
      mem_cnt <= mem_cnt_d;
      fin     <= fin_d;
    end
  end

  // fin: final record of the scan captured, wait for its drain
  always_comb begin
    state_d   = state;
    reg_cnt_d = reg_cnt;
    mem_cnt_d = mem_cnt;
    fin_d     = fin;
    in_valid  = 1'b0;
    in_tag    = TAG_REG;
    in_addr   = '0;
    in_data   = '0;
    unique case (state)
      ST_IDLE:
        if (start) state_d = ST_SETTLE;
      ST_SETTLE: begin
        reg_cnt_d = '0;
        mem_cnt_d = '0;
        fin_d     = 1'b0;
        state_d   = ST_REGS;
      end
      ST_REGS: begin
        in_valid = 1'b1;
        in_addr  = ADDR_W'(reg_cnt);
        in_data  = reg_rd_data;
        if (load_en) begin
          reg_cnt_d = reg_cnt + 1'b1;
          if (reg_cnt == '1) begin
            reg_cnt_d = '0;
            state_d   = ST_MEM;
          end
        end
      end
      ST_MEM: begin
        in_valid = !fin;
        in_tag   = TAG_MEM;
        in_addr  = ADDR_W'(mem_cnt);
        in_data  = mem_rd_data;
        if (load_en) begin
          mem_cnt_d = mem_cnt + 1'b1;
          if (mem_cnt == MEM_LAST) begin
            mem_cnt_d = '0;
`ifdef MIPS_DUMP_CHECKSUM_EN
            state_d = ST_CSUM;
`else
            fin_d = 1'b1;
`endif
          end
        end else if (fin && drained) begin
          fin_d   = 1'b0;
          state_d = ST_DONE;
        end
      end
`ifdef MIPS_DUMP_CHECKSUM_EN
      ST_CSUM: begin
        in_valid = !fin;
        in_tag   = TAG_CSUM;
        in_data  = sum;
        if (load_en) begin
          fin_d = 1'b1;
        end else if (fin && drained) begin
          fin_d   = 1'b0;
          state_d = ST_DONE;
        end
      end
`endif
      ST_DONE:
        state_d = ST_IDLE;
      default:
        state_d = ST_IDLE;
    endcase
  end

  assign halt = (state != ST_IDLE);
  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

  assign reg_rd_addr = (state == ST_REGS) ? reg_cnt : '0;
  assign mem_rd_addr = (state == ST_MEM)  ? mem_cnt : '0;

  dump_out_reg #(
    .TAG_W (2),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_out (
    .clock    (clock),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_tag   (in_tag),
    .in_addr  (in_addr),
    .in_data  (in_data),
    .out_ready(out_ready),
    .load_en  (load_en),
    .out_valid(out_valid),
    .out_tag  (out_tag),
    .out_addr (out_addr),
    .out_data (out_data)
  );

endmodule
